mc_controller: RTL and testbench

Multicycle control unit for the 64-bit MIPS datapath: a state machine that sequences one instruction over several clock cycles, sharing a single ALU and a single unified memory port between fetch, address calculation and data access. Sits beside the datapath, decodes the latched instruction's opcode/funct fields, and drives every mux select, write enable and ALU control line. Memory accesses use a ready handshake, so a slow memory simply stretches the access states.

---
 rtl/mc_pkg.sv | 63 ++++++
 rtl/mc_controller_aludec.sv | 23 ++
 rtl/mc_controller.sv | 147 ++++++++++++++
 tb/tb_mc_controller.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// states, opcode/funct constants and datapath select codes.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC,
      S_ALUWB,
      S_BRANCH,
      S_ADDIEX,
      S_ADDIWB,
      S_JUMP,
      S_TRAP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LD    = 6'b110111;
   localparam logic [5:0] OP_SD    = 6'b111111;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   function automatic state_t decode_op(input logic [5:0] op);
      state_t s;
      unique case (1'b1)
         (op == OP_LD),
         (op == OP_SD):    s = S_MEMADR;
         (op == OP_RTYPE): s = S_EXEC;
         (op == OP_BEQ):   s = S_BRANCH;
         (op == OP_ADDI):  s = S_ADDIEX;
         (op == OP_J):     s = S_JUMP;
         default:          s = S_TRAP;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// R-type funct to ALU control decoder; valid flags a supported funct.
module aludec
   import mc_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       valid
);

   always_comb begin
      alu_control = ALU_ADD;
      valid       = 1'b1;
      unique case (1'b1)
         (funct == FN_ADD): alu_control = ALU_ADD;
         (funct == FN_SUB): alu_control = ALU_SUB;
         (funct == FN_AND): alu_control = ALU_AND;
         (funct == FN_OR):  alu_control = ALU_OR;
         (funct == FN_SLT): alu_control = ALU_SLT;
         default:           valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM: sequences fetch, decode, execute and
// memory phases over a shared ALU and a single ready-handshaked memory port.
module mc_controller
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       instr_done,
   output logic       illegal
);

   state_t     state;
   state_t     state_n;
   logic [2:0] fn_alu;
   logic       fn_valid;

   aludec u_aludec (
      .funct       (funct),
      .alu_control (fn_alu),
      .valid       (fn_valid)
   );

   always_comb begin
      state_n = state;
      case (state)
         S_FETCH:  state_n = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: state_n = decode_op(op);
         S_MEMADR: state_n = (op == OP_LD) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_n = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_n = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_n = fn_valid ? S_ALUWB : S_TRAP;
         S_ADDIEX: state_n = S_ADDIWB;
         S_TRAP:   state_n = S_TRAP;
         default:  state_n = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_FETCH;
         illegal <= 1'b0;
      end else begin
         state <= state_n;
         if (state_n == S_TRAP)
            illegal <= 1'b1;
      end
   end

   always_comb begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_en       = 1'b0;
      pc_src      = PC_ALU;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_RD2;
      alu_control = ALU_ADD;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      instr_done  = 1'b0;
      case (state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
         end
         S_DECODE: alu_src_b = SRCB_IMMSH;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            mem_write  = 1'b1;
            iord       = 1'b1;
            instr_done = mem_ready;
         end
         S_EXEC: begin
            alu_src_a   = 1'b1;
            alu_control = fn_alu;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_SUB;
            pc_src      = PC_ALUOUT;
            pc_en       = zero;
            instr_done  = 1'b1;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_ADDIWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_JUMP: begin
            pc_src     = PC_JUMP;
            pc_en      = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
      // Kill strobes the instant reset drops so no partial access escapes.
      if (!reset) begin
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         pc_en      = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus
// random instruction streams checked against per-instruction totals.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'b100000;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_read, mem_write, iord, ir_write, pc_en;
   logic [1:0] pc_src, alu_src_b;
   logic       alu_src_a;
   logic [2:0] alu_control;
   logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] cyc;
      logic [7:0] rwc;
      logic [3:0] fetch;
      logic [3:0] ldacc;
      logic [3:0] st;
      logic [3:0] ir;
      logic [3:0] pc;
      logic [3:0] rw;
      logic [3:0] done;
      logic [3:0] hold;
      logic [1:0] pcsrc;
      logic       dst;
      logic       m2r;
      logic [2:0] alu;
   } st_t;

   mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
      .iord(iord), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_control(alu_control), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .instr_done(instr_done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   function automatic logic [2:0] ref_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         default:   return 3'b111;
      endcase
   endfunction

   // Expected per-instruction totals from the instruction timing table.
   function automatic st_t model(input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input int wf, input int wd);
      st_t e;
      int  c;
      e = '0;
      e.alu = 3'b011;
      e.fetch = 4'd1;
      e.ir = 4'd1;
      e.pc = 4'd1;
      e.done = 4'd1;
      c = wf;
      case (o)
         6'b000000: begin
            c += 4; e.rw = 4'd1; e.dst = 1'b1; e.alu = ref_alu(f);
         end
         6'b110111: begin
            c += 5 + wd; e.ldacc = 4'd1; e.rw = 4'd1; e.m2r = 1'b1;
         end
         6'b111111: begin
            c += 4 + wd; e.st = 4'd1;
         end
         6'b000100: begin
            c += 3; e.alu = 3'b110;
            if (z) begin e.pc = 4'd2; e.pcsrc = 2'b01; end
         end
         6'b001000: begin
            c += 4; e.rw = 4'd1;
         end
         default: begin
            c += 3; e.pc = 4'd2; e.pcsrc = 2'b10;
         end
      endcase
      e.cyc = 8'(c);
      if (e.rw != 0) e.rwc = 8'(c);
      return e;
   endfunction

   // Memory responder plus per-cycle monitor for one instruction.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                            input logic z, input int wf, input int wd,
                            output st_t ob);
      int       n;
      int       cf;
      int       cd;
      logic     pw;
      logic [2:0] pv;
      op = o; funct = f; zero = z;
      cf = wf; cd = wd;
      ob = '0; ob.alu = 3'b011;
      pw = 1'b0; pv = 3'b000; n = 0;
      while (ob.done == 0 && n < 40) begin
         @(negedge clk);
         if (mem_read || mem_write) begin
            if (!iord) begin
               mem_ready = (cf == 0);
               if (cf > 0) cf--;
            end else begin
               mem_ready = (cd == 0);
               if (cd > 0) cd--;
            end
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         #1;
         n++;
         if (pw && ({mem_read, mem_write, iord} !== pv)) ob.hold += 4'd1;
         pw = (mem_read || mem_write) && !mem_ready;
         pv = {mem_read, mem_write, iord};
         if (mem_read && mem_ready && !iord) ob.fetch += 4'd1;
         if (mem_read && mem_ready && iord) ob.ldacc += 4'd1;
         if (mem_write && mem_ready) ob.st += 4'd1;
         if (mem_write && !iord) ob.hold += 4'd1;
         if (ir_write) ob.ir += 4'd1;
         if (pc_en) begin ob.pc += 4'd1; ob.pcsrc = pc_src; end
         if (reg_write) begin
            ob.rw += 4'd1; ob.rwc = 8'(n);
            ob.dst = reg_dst; ob.m2r = mem_to_reg;
         end
         if (alu_src_a && alu_src_b == 2'b00) ob.alu = alu_control;
         if (instr_done) ob.done += 4'd1;
         if (illegal) ob.hold += 4'd1;
      end
      ob.cyc = 8'(n);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      op = 6'b000000; funct = 6'b100000; mem_ready = 1'b1; reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++;
         if ({mem_read, mem_write, ir_write, pc_en, reg_write, instr_done}
             !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 000000",
                     {mem_read, mem_write, ir_write, pc_en, reg_write,
                      instr_done});
         end
         checks++;
         if ({iord, alu_src_a, alu_src_b, alu_control, pc_src, reg_dst,
              mem_to_reg, illegal} !== 13'b0_0_01_010_00_0_0_0) begin
            errors++;
            $display("FAIL reset_defaults: got %b want 0001010000000",
                     {iord, alu_src_a, alu_src_b, alu_control, pc_src,
                      reg_dst, mem_to_reg, illegal});
         end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_rtype();
      st_t ob, ex;
      run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, ob);
      ex = model(6'b000000, 6'b100000, 1'b0, 0, 0);
      checks++;
      if (ob !== ex) begin
         errors++;
         $display("FAIL rtype_add: got %h want %h", ob, ex);
      end
      checks++;
      if (ob.cyc !== 8'd4 || ob.rwc !== 8'd4 || ob.dst !== 1'b1) begin
         errors++;
         $display("FAIL rtype_timing: cyc %0d rwc %0d dst %b want 4 4 1",
                  ob.cyc, ob.rwc, ob.dst);
      end
   endtask

   task automatic test_ld_waits();
      st_t ob, ex;
      run_instr(6'b110111, 6'b000000, 1'b0, 2, 3, ob);
      ex = model(6'b110111, 6'b000000, 1'b0, 2, 3);
      checks++;
      if (ob !== ex) begin
         errors++;
         $display("FAIL ld_waits: got %h want %h", ob, ex);
      end
      checks++;
      if (ob.cyc !== 8'd10 || ob.m2r !== 1'b1 || ob.hold !== 4'd0) begin
         errors++;
         $display("FAIL ld_timing: cyc %0d m2r %b hold %0d want 10 1 0",
                  ob.cyc, ob.m2r, ob.hold);
      end
   endtask

   task automatic test_branch();
      st_t ob, ex;
      run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, ob);
      ex = model(6'b000100, 6'b000000, 1'b1, 0, 0);
      checks++;
      if (ob !== ex || ob.pcsrc !== 2'b01 || ob.cyc !== 8'd3) begin
         errors++;
         $display("FAIL beq_taken: got %h want %h", ob, ex);
      end
      run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, ob);
      ex = model(6'b000100, 6'b000000, 1'b0, 0, 0);
      checks++;
      if (ob !== ex || ob.pc !== 4'd1 || ob.done !== 4'd1) begin
         errors++;
         $display("FAIL beq_not_taken: got %h want %h", ob, ex);
      end
   endtask

   task automatic test_back_to_back();
      st_t ob, ex;
      int  dones;
      int  cycs;
      dones = 0; cycs = 0;
      run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, ob);
      ex = model(6'b111111, 6'b000000, 1'b0, 0, 0);
      dones += int'(ob.done); cycs += int'(ob.cyc);
      checks++;
      if (ob !== ex || ob.st !== 4'd1) begin
         errors++;
         $display("FAIL b2b_sd: got %h want %h", ob, ex);
      end
      run_instr(6'b001000, 6'b000000, 1'b0, 0, 0, ob);
      ex = model(6'b001000, 6'b000000, 1'b0, 0, 0);
      dones += int'(ob.done); cycs += int'(ob.cyc);
      checks++;
      if (ob !== ex || ob.dst !== 1'b0) begin
         errors++;
         $display("FAIL b2b_addi: got %h want %h", ob, ex);
      end
      run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, ob);
      ex = model(6'b000010, 6'b000000, 1'b0, 0, 0);
      dones += int'(ob.done); cycs += int'(ob.cyc);
      checks++;
      if (ob !== ex || ob.pcsrc !== 2'b10) begin
         errors++;
         $display("FAIL b2b_j: got %h want %h", ob, ex);
      end
      checks++;
      if (dones != 3 || cycs != 11) begin
         errors++;
         $display("FAIL b2b_totals: done %0d cycles %0d want 3 11",
                  dones, cycs);
      end
   endtask

   task automatic trap_case(input logic [5:0] o, input logic [5:0] f,
                            input int ncyc);
      int strobes;
      op = o; funct = f; mem_ready = 1'b1; strobes = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk); #1;
         if (i >= ncyc - 4 &&
             (mem_read || mem_write || ir_write || pc_en || reg_write ||
              instr_done))
            strobes++;
         if (reg_write || instr_done) strobes++;
      end
      checks++;
      if (illegal !== 1'b1 || strobes != 0) begin
         errors++;
         $display("FAIL trap_%b_%b: illegal %b strobes %0d want 1 0",
                  o, f, illegal, strobes);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (illegal !== 1'b0) begin
         errors++;
         $display("FAIL trap_clear: illegal %b want 0", illegal);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_illegal();
      trap_case(6'b111000, 6'b000000, 8);
      trap_case(6'b000000, 6'b000111, 9);
   endtask

   task automatic test_reset_midwrite();
      op = 6'b111111; funct = 6'b000000; mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (mem_write !== 1'b1 || iord !== 1'b1) begin
         errors++;
         $display("FAIL midwr_pre: mem_write %b iord %b want 1 1",
                  mem_write, iord);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (mem_write !== 1'b0 || instr_done !== 1'b0) begin
         errors++;
         $display("FAIL midwr_abort: mem_write %b done %b want 0 0",
                  mem_write, instr_done);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (mem_read !== 1'b1 || iord !== 1'b0 || alu_src_b !== 2'b01) begin
         errors++;
         $display("FAIL midwr_restart: rd %b iord %b srcb %b want 1 0 01",
                  mem_read, iord, alu_src_b);
      end
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_random();
      logic [5:0] ops [6];
      logic [5:0] fns [5];
      st_t        ob, ex;
      logic [5:0] o, f;
      logic       z;
      int         wf, wd;
      ops = '{6'b000000, 6'b110111, 6'b111111, 6'b000100, 6'b001000,
              6'b000010};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      for (int i = 0; i < 60; i++) begin
         o  = ops[$urandom_range(0, 5)];
         f  = fns[$urandom_range(0, 4)];
         z  = 1'($urandom_range(0, 1));
         wf = $urandom_range(0, 3);
         wd = $urandom_range(0, 3);
         run_instr(o, f, z, wf, wd, ob);
         ex = model(o, f, z, wf, wd);
         checks++;
         if (ob !== ex) begin
            errors++;
            $display("FAIL rand_%0d op %b fn %b z %b wf %0d wd %0d: got %h want %h",
                     i, o, f, z, wf, wd, ob, ex);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_ld_waits();
      test_branch();
      test_back_to_back();
      test_illegal();
      test_reset_midwrite();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
